// File: rtl/scpad_dram_arbiter.sv
// Round-robin arbiter sharing one DRAM request port between scratchpad backend queues.
// Tags requests with their source, tracks outstanding counts and routes responses back.
module scpad_dram_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NB_W      = 5,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned MAX_OUTST = 8,
    localparam int unsigned SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*NB_W-1:0]   req_num_bytes,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      dram_req_valid,
    output logic                      dram_req_write,
    output logic [ADDR_W-1:0]         dram_req_addr,
    output logic [NB_W-1:0]           dram_req_num_bytes,
    output logic [DATA_W-1:0]         dram_req_wdata,
    output logic [SRC_W+ID_W-1:0]     dram_req_id,
    input  logic                      dram_stall,
    input  logic                      dram_rsp_valid,
    input  logic                      dram_rsp_write,
    input  logic [SRC_W+ID_W-1:0]     dram_rsp_id,
    input  logic [DATA_W-1:0]         dram_rsp_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_write,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [NUM_REQ-1:0]        outst_full,
    output logic                      rsp_err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned TAG_W = SRC_W + ID_W;

    typedef enum logic {EMPTY, HELD} state_t;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     last_grant_q;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [NUM_REQ-1:0]   elig;
    logic                 load_ok;
    logic                 transfer;
    logic [CNT_W-1:0]     cnt_q [NUM_REQ];
    logic [CNT_W-1:0]     cnt_d [NUM_REQ];
    logic [SRC_W-1:0]     rsp_src;
    logic                 src_ok;
    logic [NUM_REQ-1:0]   rsp_hit;
    logic                 err_set;

    assign load_ok   = (state_q == EMPTY) || !dram_stall;
    assign elig      = req_valid & ~outst_full;
    assign req_ready = grant_oh & {NUM_REQ{load_ok}};
    assign transfer  = grant_any && load_ok;
    assign dram_req_valid = (state_q == HELD);

    // Round-robin search starting one past the last winner
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!grant_any && elig[SRC_W'((32'(last_grant_q) + k) % NUM_REQ)]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'((32'(last_grant_q) + k) % NUM_REQ);
            end
        end
        if (grant_any) grant_oh[grant_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (grant_any) state_d = HELD;
            HELD:    if (!dram_stall) state_d = grant_any ? HELD : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output request register, reloaded only on a transfer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant_q       <= SRC_W'(NUM_REQ - 1);
            dram_req_write     <= 1'b0;
            dram_req_addr      <= '0;
            dram_req_num_bytes <= '0;
            dram_req_wdata     <= '0;
            dram_req_id        <= '0;
        end else if (transfer) begin
            last_grant_q       <= grant_idx;
            dram_req_write     <= req_write[grant_idx];
            dram_req_addr      <= req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
            dram_req_num_bytes <= req_num_bytes[32'(grant_idx)*NB_W +: NB_W];
            dram_req_wdata     <= req_wdata[32'(grant_idx)*DATA_W +: DATA_W];
            dram_req_id        <= {grant_idx, req_id[32'(grant_idx)*ID_W +: ID_W]};
        end
    end

    assign rsp_src = dram_rsp_id[TAG_W-1:ID_W];
    assign src_ok  = 32'(rsp_src) < NUM_REQ;

    // Per-source outstanding counters; a zero count is not decremented but flags an error
    always_comb begin
        cnt_d   = cnt_q;
        rsp_hit = '0;
        err_set = dram_rsp_valid && !src_ok;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_hit[i] = dram_rsp_valid && src_ok && (rsp_src == SRC_W'(i));
            if (rsp_hit[i] && cnt_q[i] == '0) err_set = 1'b1;
            if (req_ready[i] && cnt_q[i] != CNT_W'(MAX_OUTST) &&
                !(rsp_hit[i] && cnt_q[i] != '0))
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (!req_ready[i] && rsp_hit[i] && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(NUM_REQ); i++) cnt_q[i] <= '0;
            outst_full <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cnt_q[i]      <= cnt_d[i];
                outst_full[i] <= (cnt_d[i] == CNT_W'(MAX_OUTST));
            end
        end
    end

    // Response routing register; fields broadcast, valid one-hot
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_valid <= '0;
            rsp_write <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= rsp_hit;
            rsp_err   <= rsp_err | err_set;
            if (dram_rsp_valid) begin
                rsp_write <= dram_rsp_write;
                rsp_id    <= dram_rsp_id[ID_W-1:0];
                rsp_rdata <= dram_rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_scpad_dram_arbiter.sv
// Directed bench for scpad_dram_arbiter: grant order, stall hold, outstanding limit,
// response routing, error flag and asynchronous reset.
module tb_scpad_dram_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned NB_W    = 5;
    localparam int unsigned DATA_W  = 256;
    localparam int unsigned SRC_W   = 1;

    logic                      clk = 1'b0;
    logic                      nrst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ID_W-1:0]   req_id;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*NB_W-1:0]   req_num_bytes;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      dram_req_valid;
    logic                      dram_req_write;
    logic [ADDR_W-1:0]         dram_req_addr;
    logic [NB_W-1:0]           dram_req_num_bytes;
    logic [DATA_W-1:0]         dram_req_wdata;
    logic [SRC_W+ID_W-1:0]     dram_req_id;
    logic                      dram_stall;
    logic                      dram_rsp_valid;
    logic                      dram_rsp_write;
    logic [SRC_W+ID_W-1:0]     dram_rsp_id;
    logic [DATA_W-1:0]         dram_rsp_rdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_write;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [NUM_REQ-1:0]        outst_full;
    logic                      rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    scpad_dram_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .NB_W(NB_W),
        .DATA_W(DATA_W), .MAX_OUTST(8)
    ) dut (
        .CLK(clk), .nRST(nrst),
        .req_valid(req_valid), .req_write(req_write), .req_id(req_id),
        .req_addr(req_addr), .req_num_bytes(req_num_bytes), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .dram_req_valid(dram_req_valid), .dram_req_write(dram_req_write),
        .dram_req_addr(dram_req_addr), .dram_req_num_bytes(dram_req_num_bytes),
        .dram_req_wdata(dram_req_wdata), .dram_req_id(dram_req_id),
        .dram_stall(dram_stall),
        .dram_rsp_valid(dram_rsp_valid), .dram_rsp_write(dram_rsp_write),
        .dram_rsp_id(dram_rsp_id), .dram_rsp_rdata(dram_rsp_rdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_id(rsp_id),
        .rsp_rdata(rsp_rdata), .outst_full(outst_full), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic w,
                           input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr);
        req_valid[s]                   = v;
        req_write[s]                   = w;
        req_id[s*ID_W +: ID_W]         = id;
        req_addr[s*ADDR_W +: ADDR_W]   = addr;
        req_num_bytes[s*NB_W +: NB_W]  = 5'd31;
        req_wdata[s*DATA_W +: DATA_W]  = {8{addr}};
    endtask

    task automatic send_rsp(input logic w, input logic [SRC_W+ID_W-1:0] id,
                            input logic [DATA_W-1:0] data);
        dram_rsp_valid = 1'b1;
        dram_rsp_write = w;
        dram_rsp_id    = id;
        dram_rsp_rdata = data;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        dram_rsp_valid = 1'b0;
    endtask

    logic [NUM_REQ-1:0] exp_g;
    int                 g0, g1;

    initial begin
        nrst = 1'b0;
        req_valid = '0; req_write = '0; req_id = '0; req_addr = '0;
        req_num_bytes = '0; req_wdata = '0;
        dram_stall = 1'b0; dram_rsp_valid = 1'b0; dram_rsp_write = 1'b0;
        dram_rsp_id = '0; dram_rsp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dram_req_valid", dram_req_valid, 0);
        chk("reset_dram_req_id", dram_req_id, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_outst_full", outst_full, 0);
        chk("reset_rsp_err", rsp_err, 0);
        nrst = 1'b1;

        // single read from source 0
        set_src(0, 1'b1, 1'b0, 8'h12, 32'h1000);
        #1 chk("single_ready", req_ready, 2'b01);
        tick();
        set_src(0, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("single_req_valid", dram_req_valid, 1);
        chk("single_req_id", dram_req_id, 9'h012);
        chk("single_req_addr", dram_req_addr, 32'h1000);
        chk("single_req_write", dram_req_write, 0);
        chk("single_cnt0", dut.cnt_q[0], 1);
        send_rsp(1'b0, 9'h012, {32{8'hAB}});
        tick();
        chk("single_rsp_valid", rsp_valid, 2'b01);
        chk("single_rsp_id", rsp_id, 8'h12);
        chk("single_rsp_rdata", rsp_rdata, {32{8'hAB}});
        chk("single_cnt0_back", dut.cnt_q[0], 0);
        chk("single_rsp_err", rsp_err, 0);

        // fairness: last winner was 0, so source 1 leads
        set_src(0, 1'b1, 1'b0, 8'h20, 32'h2000);
        set_src(1, 1'b1, 1'b0, 8'h21, 32'h2100);
        exp_g = 2'b10; g0 = 0; g1 = 0;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_ready", req_ready, exp_g);
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
            tick();
            chk("fair_req_id", dram_req_id, exp_g[1] ? 9'h121 : 9'h020);
            exp_g = ~exp_g;
        end
        chk("fair_count0", g0, 4);
        chk("fair_count1", g1, 4);
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            send_rsp(1'b0, (k % 2 == 0) ? 9'h020 : 9'h121, '0);
            tick();
            chk("fair_rsp_route", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        chk("fair_drained0", dut.cnt_q[0], 0);
        chk("fair_drained1", dut.cnt_q[1], 0);

        // stall hold with source 1 in the register
        set_src(1, 1'b1, 1'b1, 8'h31, 32'h3100);
        #1 chk("stall_first_ready", req_ready, 2'b10);
        tick();
        set_src(1, 1'b0, 1'b0, 8'h00, 32'h0);
        set_src(0, 1'b1, 1'b0, 8'h30, 32'h3000);
        dram_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_req_id", dram_req_id, 9'h131);
            chk("stall_req_addr", dram_req_addr, 32'h3100);
            chk("stall_req_write", dram_req_write, 1);
            tick();
        end
        dram_stall = 1'b0;
        #1 chk("stall_release_ready", req_ready, 2'b01);
        tick();
        set_src(0, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("stall_reload_id", dram_req_id, 9'h030);
        chk("stall_reload_wdata", dram_req_wdata, {8{32'h3000}});
        send_rsp(1'b1, 9'h131, '0);
        tick();
        chk("stall_wack_route", rsp_valid, 2'b10);
        chk("stall_wack_write", rsp_write, 1);
        send_rsp(1'b0, 9'h030, '0);
        tick();
        chk("stall_rsp0_route", rsp_valid, 2'b01);

        // outstanding limit on source 1
        set_src(1, 1'b1, 1'b0, 8'h40, 32'h4000);
        for (int k = 0; k < 8; k++) begin
            #1 chk("limit_ready", req_ready, 2'b10);
            tick();
        end
        chk("limit_full", outst_full, 2'b10);
        chk("limit_cnt1", dut.cnt_q[1], 8);
        #1 chk("limit_skip_ready", req_ready, 2'b00);
        set_src(0, 1'b1, 1'b0, 8'h41, 32'h4100);
        #1 chk("limit_src0_ready", req_ready, 2'b01);
        tick();
        set_src(0, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("limit_src0_id", dram_req_id, 9'h041);
        #1 chk("limit_still_blocked", req_ready, 2'b00);
        send_rsp(1'b0, 9'h140, '0);
        tick();
        chk("limit_rsp_route", rsp_valid, 2'b10);
        chk("limit_unfull", outst_full, 2'b00);
        #1 chk("limit_regrant", req_ready, 2'b10);
        tick();
        set_src(1, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("limit_refull", outst_full, 2'b10);
        for (int k = 0; k < 8; k++) begin
            send_rsp(1'b0, 9'h140, '0);
            tick();
        end
        send_rsp(1'b0, 9'h041, '0);
        tick();
        chk("limit_drained0", dut.cnt_q[0], 0);
        chk("limit_drained1", dut.cnt_q[1], 0);
        chk("limit_no_err", rsp_err, 0);

        // simultaneous accept and response on source 0, then error on source 1
        set_src(0, 1'b1, 1'b0, 8'h50, 32'h5000);
        #1 chk("simul_ready_a", req_ready, 2'b01);
        tick();
        chk("simul_cnt_a", dut.cnt_q[0], 1);
        send_rsp(1'b0, 9'h050, {8{32'h55AA55AA}});
        #1 chk("simul_ready_b", req_ready, 2'b01);
        tick();
        set_src(0, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("simul_cnt_same", dut.cnt_q[0], 1);
        chk("simul_rsp_route", rsp_valid, 2'b01);
        chk("simul_no_err", rsp_err, 0);
        send_rsp(1'b0, 9'h151, '0);
        tick();
        chk("err_set", rsp_err, 1);
        chk("err_still_routed", rsp_valid, 2'b10);
        chk("err_cnt1_zero", dut.cnt_q[1], 0);
        repeat (3) tick();
        chk("err_sticky", rsp_err, 1);

        // build cnt = {3, 2} then reset while HELD
        set_src(0, 1'b1, 1'b0, 8'h60, 32'h6000);
        set_src(1, 1'b1, 1'b0, 8'h61, 32'h6100);
        repeat (3) tick();
        set_src(1, 1'b0, 1'b0, 8'h61, 32'h6100);
        #1 chk("rst_pre_ready", req_ready, 2'b01);
        tick();
        dram_stall = 1'b1;
        set_src(0, 1'b0, 1'b0, 8'h60, 32'h6000);
        chk("rst_pre_cnt0", dut.cnt_q[0], 3);
        chk("rst_pre_cnt1", dut.cnt_q[1], 2);
        chk("rst_pre_held", dram_req_valid, 1);
        #1 nrst = 1'b0;
        #1;
        chk("rst_req_valid", dram_req_valid, 0);
        chk("rst_req_id", dram_req_id, 0);
        chk("rst_req_addr", dram_req_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cnt0", dut.cnt_q[0], 0);
        chk("rst_cnt1", dut.cnt_q[1], 0);
        tick();
        nrst = 1'b1;
        dram_stall = 1'b0;
        set_src(0, 1'b1, 1'b0, 8'h70, 32'h7000);
        set_src(1, 1'b1, 1'b0, 8'h71, 32'h7100);
        #1 chk("rst_first_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("rst_first_id", dram_req_id, 9'h070);
        send_rsp(1'b0, 9'h161, '0);
        tick();
        chk("rst_stale_rsp_err", rsp_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
